// File: rtl/alu_issue_if.sv
// Operand-issue bundle between the decode stage, alu_issue and the ALU/writeback side.
// The issuer takes the master view; the surrounding environment takes the slave view.
interface alu_issue_if #(
  parameter int XLEN   = 32,
  parameter int ALUC_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_inst;
  logic [XLEN-1:0]   in_pc;
  logic [XLEN-1:0]   in_rs1_data;
  logic [XLEN-1:0]   in_rs2_data;
  logic              out_valid;
  logic              out_ready;
  logic [ALUC_W-1:0] out_aluc;
  logic [XLEN-1:0]   out_num1;
  logic [XLEN-1:0]   out_num2;
  logic [3:0]        out_rd;
  logic              out_wen;
  logic              out_illegal;
  logic              halted;

  modport master (
    input  in_valid, in_inst, in_pc, in_rs1_data, in_rs2_data, out_ready,
    output in_ready, out_valid, out_aluc, out_num1, out_num2, out_rd, out_wen,
           out_illegal, halted
  );

  modport slave (
    output in_valid, in_inst, in_pc, in_rs1_data, in_rs2_data, out_ready,
    input  in_ready, out_valid, out_aluc, out_num1, out_num2, out_rd, out_wen,
           out_illegal, halted
  );
endinterface

// File: rtl/alu_issue.sv
// Decodes the supported RV32E subset into ALU operands and issues them through a
// 2-entry (head + skid) buffer; an illegal instruction is passed along flagged and halts intake.
module alu_issue #(
  parameter int XLEN   = 32,
  parameter int ALUC_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  alu_issue_if.master bus
);
  localparam logic [ALUC_W-1:0] ALU_ADD  = ALUC_W'(1);
  localparam logic [ALUC_W-1:0] ALU_SUB  = ALUC_W'(2);
  localparam logic [ALUC_W-1:0] ALU_JALR = ALUC_W'(3);

  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  typedef struct packed {
    logic [ALUC_W-1:0] aluc;
    logic [XLEN-1:0]   num1;
    logic [XLEN-1:0]   num2;
    logic [3:0]        rd;
    logic              wen;
    logic              illegal;
  } entry_t;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  state_t      r_state, w_nxt;
  entry_t      r_head, r_skid, w_dec;
  logic        r_halted;
  logic        w_ok, w_in_ready, w_in_x, w_out_x;
  logic        w_ld_head, w_ld_skid, w_head_from_skid;
  logic [6:0]  w_op;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [XLEN-1:0] w_imm_i, w_imm_u;

  assign w_op    = bus.in_inst[6:0];
  assign w_f3    = bus.in_inst[14:12];
  assign w_f7    = bus.in_inst[31:25];
  assign w_imm_i = XLEN'($signed(bus.in_inst[31:20]));
  assign w_imm_u = XLEN'($signed({bus.in_inst[31:12], 12'b0}));

  // Register index checks only apply to fields the instruction actually uses;
  // elsewhere those bits are immediate.
  always_comb begin
    w_dec    = '0;
    w_ok     = 1'b0;
    w_dec.rd = bus.in_inst[10:7];
    case (w_op)
      OP_IMM: if (w_f3 == 3'b000 && !bus.in_inst[19]) begin
        w_ok = 1'b1; w_dec.aluc = ALU_ADD;
        w_dec.num1 = bus.in_rs1_data; w_dec.num2 = w_imm_i;
      end
      OP_REG: if (w_f3 == 3'b000 && !bus.in_inst[19] && !bus.in_inst[24] &&
                  (w_f7 == 7'h00 || w_f7 == 7'h20)) begin
        w_ok = 1'b1; w_dec.aluc = (w_f7 == 7'h20) ? ALU_SUB : ALU_ADD;
        w_dec.num1 = bus.in_rs1_data; w_dec.num2 = bus.in_rs2_data;
      end
      OP_LUI: begin
        w_ok = 1'b1; w_dec.aluc = ALU_ADD; w_dec.num1 = '0; w_dec.num2 = w_imm_u;
      end
      OP_AUIPC: begin
        w_ok = 1'b1; w_dec.aluc = ALU_ADD; w_dec.num1 = bus.in_pc; w_dec.num2 = w_imm_u;
      end
      OP_JAL: begin
        w_ok = 1'b1; w_dec.aluc = ALU_ADD; w_dec.num1 = bus.in_pc; w_dec.num2 = XLEN'(4);
      end
      OP_JALR: if (w_f3 == 3'b000 && !bus.in_inst[19]) begin
        w_ok = 1'b1; w_dec.aluc = ALU_JALR;
        w_dec.num1 = bus.in_rs1_data; w_dec.num2 = w_imm_i;
      end
      default: w_ok = 1'b0;
    endcase
    if (bus.in_inst[11]) w_ok = 1'b0;
    if (!w_ok) begin
      w_dec.aluc = '0;
      w_dec.num1 = XLEN'(bus.in_inst);
      w_dec.num2 = bus.in_pc;
    end
    w_dec.illegal = !w_ok;
    w_dec.wen     = w_ok && (w_dec.rd != 4'd0);
  end

  assign w_in_ready = (r_state != S_TWO) && !r_halted && !rst;
  assign w_in_x     = bus.in_valid && w_in_ready;
  assign w_out_x    = (r_state != S_EMPTY) && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_EMPTY;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt            = r_state;
    w_ld_head        = 1'b0;
    w_ld_skid        = 1'b0;
    w_head_from_skid = 1'b0;
    case (r_state)
      S_EMPTY: if (w_in_x) begin w_nxt = S_ONE; w_ld_head = 1'b1; end
      S_ONE: begin
        if (w_in_x && w_out_x) w_ld_head = 1'b1;
        else if (w_in_x)  begin w_nxt = S_TWO; w_ld_skid = 1'b1; end
        else if (w_out_x) w_nxt = S_EMPTY;
      end
      S_TWO: if (w_out_x) begin
        w_nxt = S_ONE; w_ld_head = 1'b1; w_head_from_skid = 1'b1;
      end
      default: w_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head   <= '0;
      r_skid   <= '0;
      r_halted <= 1'b0;
    end else begin
      if (w_ld_head) r_head <= w_head_from_skid ? r_skid : w_dec;
      if (w_ld_skid) r_skid <= w_dec;
      if (w_in_x && w_dec.illegal) r_halted <= 1'b1;
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = (r_state != S_EMPTY);
  assign bus.out_aluc    = r_head.aluc;
  assign bus.out_num1    = r_head.num1;
  assign bus.out_num2    = r_head.num2;
  assign bus.out_rd      = r_head.rd;
  assign bus.out_wen     = r_head.wen;
  assign bus.out_illegal = r_head.illegal;
  assign bus.halted      = r_halted;
endmodule
